// File: rtl/compare_block.sv
// Read-data checker: queues accepted read commands, regenerates the written pattern per beat
// and compares Avalon-MM readdata under first/last-beat byte masks, latching the first mismatch.
module compare_block #(
    parameter int AMM_DATA_W     = 128,
    parameter int AMM_ADDR_W     = 12,
    parameter int AMM_BURST_W    = 11,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int BYTE_PER_WORD  = AMM_DATA_W / 8,
    parameter int BYTE_ADDR_W    = $clog2(BYTE_PER_WORD),
    parameter int ADDR_W         = AMM_ADDR_W - BYTE_ADDR_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [ADDR_W-1:0]      cmd_addr_i,
    input  logic [AMM_BURST_W-1:0] cmd_burst_i,
    input  logic [BYTE_ADDR_W-1:0] cmd_start_off_i,
    input  logic [BYTE_ADDR_W-1:0] cmd_end_off_i,
    input  logic [7:0]             cmd_seed_i,
    input  logic                   rnd_mode_i,
    input  logic                   readdatavalid_i,
    input  logic [AMM_DATA_W-1:0]  readdata_i,
    output logic                   error_check_o,
    output logic                   unexp_rd_o,
    output logic [ADDR_W-1:0]      err_addr_o,
    output logic [AMM_DATA_W-1:0]  err_data_o,
    output logic [AMM_DATA_W-1:0]  err_exp_o,
    output logic [15:0]            err_cnt_o,
    output logic                   busy_o
);
    localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(CMD_FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [AMM_BURST_W-1:0] burst;
        logic [BYTE_ADDR_W-1:0] soff;
        logic [BYTE_ADDR_W-1:0] eoff;
        logic [7:0]             seed;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK} state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] p);
        return {p[6:0], p[6] ^ p[1] ^ p[0]};
    endfunction

    cmd_t                   fifo_mem [CMD_FIFO_DEPTH];
    cmd_t                   cmd_in, head;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [PTR_W:0]         fifo_cnt;
    logic                   fifo_empty, fifo_full, push, pop;

    state_t                 state;
    logic [AMM_BURST_W-1:0] beat_idx, cur_idx;
    logic [7:0]             pat, cur_pat;
    logic                   fresh, last, beat, unexp, mismatch;
    logic [BYTE_PER_WORD-1:0] byte_mask, byte_diff;
    logic [AMM_DATA_W-1:0]  exp_word;

    assign cmd_in     = '{addr: cmd_addr_i, burst: cmd_burst_i, soff: cmd_start_off_i,
                          eoff: cmd_end_off_i, seed: cmd_seed_i};
    assign head       = fifo_mem[rd_ptr];
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign cmd_ready_o = !fifo_full;
    assign busy_o     = (state != S_IDLE) || !fifo_empty;

    // Head of the FIFO is always the command being checked; outside CHECK the beat state is
    // taken straight from the head so a beat landing in IDLE/LOAD is treated as beat 0.
    assign fresh    = (state != S_CHECK);
    assign cur_idx  = fresh ? '0 : beat_idx;
    assign cur_pat  = fresh ? head.seed : pat;
    assign last     = (cur_idx == head.burst - 1'b1);
    assign exp_word = {BYTE_PER_WORD{cur_pat}};
    assign beat     = readdatavalid_i && !fifo_empty;
    assign unexp    = readdatavalid_i && fifo_empty;
    assign pop      = beat && last;
    // A slot freed by this cycle's pop may be refilled even while full.
    assign push     = cmd_valid_i && (!fifo_full || pop);

    always_comb begin
        byte_mask = '1;
        byte_diff = '0;
        for (int i = 0; i < BYTE_PER_WORD; i++) begin
            byte_diff[i] = (readdata_i[i*8 +: 8] != cur_pat);
            if (cur_idx == '0 && BYTE_ADDR_W'(i) < head.soff) byte_mask[i] = 1'b0;
            if (last && BYTE_ADDR_W'(i) > head.eoff)          byte_mask[i] = 1'b0;
        end
    end

    assign mismatch = beat && |(byte_mask & byte_diff);

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= cmd_in;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            beat_idx <= '0;
            pat      <= '0;
        end else if (beat) begin
            if (last) begin
                state    <= (|fifo_cnt[PTR_W:1] || push) ? S_LOAD : S_IDLE;
                beat_idx <= '0;
            end else begin
                state    <= S_CHECK;
                beat_idx <= cur_idx + 1'b1;
                pat      <= rnd_mode_i ? lfsr_next(cur_pat) : cur_pat;
            end
        end else begin
            case (state)
                S_IDLE: if (!fifo_empty) state <= S_LOAD;
                S_LOAD: begin
                    state    <= S_CHECK;
                    beat_idx <= '0;
                    pat      <= head.seed;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            error_check_o <= 1'b0;
            unexp_rd_o    <= 1'b0;
            err_addr_o    <= '0;
            err_data_o    <= '0;
            err_exp_o     <= '0;
            err_cnt_o     <= '0;
        end else if (clear_i) begin
            error_check_o <= 1'b0;
            unexp_rd_o    <= 1'b0;
            err_addr_o    <= '0;
            err_data_o    <= '0;
            err_exp_o     <= '0;
            err_cnt_o     <= '0;
        end else begin
            if (unexp) begin
                unexp_rd_o    <= 1'b1;
                error_check_o <= 1'b1;
            end
            if (mismatch) begin
                error_check_o <= 1'b1;
                // A zero count means no mismatch has been captured since the last clear.
                if (err_cnt_o == '0) begin
                    err_addr_o <= head.addr + ADDR_W'(cur_idx);
                    err_data_o <= readdata_i;
                    err_exp_o  <= exp_word;
                end
                if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_compare_block.sv
// Directed bench for compare_block: hand-computed expectations checked with immediate assertions.
module tb_compare_block;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         clear_i = 1'b0;
    logic         cmd_valid_i = 1'b0;
    logic         cmd_ready_o;
    logic [7:0]   cmd_addr_i = '0;
    logic [10:0]  cmd_burst_i = '0;
    logic [3:0]   cmd_start_off_i = '0;
    logic [3:0]   cmd_end_off_i = '0;
    logic [7:0]   cmd_seed_i = '0;
    logic         rnd_mode_i = 1'b0;
    logic         readdatavalid_i = 1'b0;
    logic [127:0] readdata_i = '0;
    logic         error_check_o, unexp_rd_o, busy_o;
    logic [7:0]   err_addr_o;
    logic [127:0] err_data_o, err_exp_o;
    logic [15:0]  err_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    compare_block dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_burst_i(cmd_burst_i),
        .cmd_start_off_i(cmd_start_off_i), .cmd_end_off_i(cmd_end_off_i),
        .cmd_seed_i(cmd_seed_i), .rnd_mode_i(rnd_mode_i),
        .readdatavalid_i(readdatavalid_i), .readdata_i(readdata_i),
        .error_check_o(error_check_o), .unexp_rd_o(unexp_rd_o),
        .err_addr_o(err_addr_o), .err_data_o(err_data_o), .err_exp_o(err_exp_o),
        .err_cnt_o(err_cnt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [10:0] b, input logic [3:0] so,
                        input logic [3:0] eo, input logic [7:0] s);
        cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_burst_i = b;
        cmd_start_off_i = so; cmd_end_off_i = eo; cmd_seed_i = s;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic beat(input logic [127:0] d);
        readdatavalid_i = 1'b1; readdata_i = d;
        tick();
        readdatavalid_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        logic [7:0]   s;

        tick(); tick();
        chk("rst_ready", cmd_ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", error_check_o, 1'b0);
        chk("rst_cnt", err_cnt_o, 16'h0);
        rst_i = 1'b0;
        tick();

        // 1: fixed pattern, full-mask burst of 4, first beat lands during LOAD
        rnd_mode_i = 1'b0;
        push(8'h10, 11'd4, 4'd0, 4'd15, 8'hA5);
        chk("t1_busy", busy_o, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) beat({16{8'hA5}});
        chk("t1_err", error_check_o, 1'b0);
        chk("t1_cnt", err_cnt_o, 16'h0);
        chk("t1_busy_done", busy_o, 1'b0);
        chk("t1_ready", cmd_ready_o, 1'b1);

        // 2: LFSR seed FF, beat1 byte5 flipped, then a second mismatch that must not relatch
        rnd_mode_i = 1'b1;
        push(8'h20, 11'd3, 4'd0, 4'd15, 8'hFF);
        beat({16{8'hFF}});
        d = {16{8'hFF}};
        d[47:40] = 8'h00;
        beat(d);
        chk("t2_err", error_check_o, 1'b1);
        chk("t2_addr", err_addr_o, 8'h21);
        chk("t2_data", err_data_o, d);
        chk("t2_exp", err_exp_o, {16{8'hFF}});
        chk("t2_cnt", err_cnt_o, 16'h1);
        beat({16{8'h00}});
        chk("t2_cnt2", err_cnt_o, 16'h2);
        chk("t2_addr_hold", err_addr_o, 8'h21);
        do_clear();
        chk("t2_clr_err", error_check_o, 1'b0);
        chk("t2_clr_cnt", err_cnt_o, 16'h0);

        // 2b: LFSR sequence 01 -> 03 -> 06, last beat wrong; address wraps FF+2 -> 01
        push(8'hFF, 11'd3, 4'd0, 4'd15, 8'h01);
        beat({16{8'h01}});
        beat({16{8'h03}});
        chk("t2b_noerr", error_check_o, 1'b0);
        beat({16{8'h00}});
        chk("t2b_err", error_check_o, 1'b1);
        chk("t2b_addr", err_addr_o, 8'h01);
        chk("t2b_exp", err_exp_o, {16{8'h06}});
        do_clear();

        // 3: single beat, mask bytes 4..9
        rnd_mode_i = 1'b0;
        push(8'h30, 11'd1, 4'd4, 4'd9, 8'h3C);
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = (i >= 4 && i <= 9) ? 8'h3C : 8'hC3;
        beat(d);
        chk("t3_masked", error_check_o, 1'b0);
        push(8'h30, 11'd1, 4'd4, 4'd9, 8'h3C);
        d = {16{8'h3C}};
        d[39:32] = 8'h00;
        beat(d);
        chk("t3_byte4", error_check_o, 1'b1);
        chk("t3_addr", err_addr_o, 8'h30);
        // two beats: only byte 15 of beat 0 and byte 0 of beat 1 are live
        push(8'h31, 11'd2, 4'd15, 4'd0, 8'h3C);
        d = {16{8'hC3}};
        d[127:120] = 8'h3C;
        beat(d);
        d = {16{8'hC3}};
        d[7:0] = 8'h3C;
        beat(d);
        chk("t3_edge_cnt", err_cnt_o, 16'h1);
        do_clear();

        // 4: five back-to-back commands, fifth refused; four checked in order
        for (int k = 0; k < 5; k++) begin
            s = 8'h10 + 8'(k);
            cmd_valid_i = 1'b1; cmd_addr_i = 8'h40 + 8'(k); cmd_burst_i = 11'd2;
            cmd_start_off_i = 4'd0; cmd_end_off_i = 4'd15; cmd_seed_i = s;
            chk($sformatf("t4_ready%0d", k), cmd_ready_o, (k < 4) ? 1'b1 : 1'b0);
            tick();
        end
        cmd_valid_i = 1'b0;
        chk("t4_busy", busy_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            s = 8'h10 + 8'(k);
            beat({16{s}});
            beat({16{s}});
        end
        chk("t4_err", error_check_o, 1'b0);
        chk("t4_busy_done", busy_o, 1'b0);
        chk("t4_ready_back", cmd_ready_o, 1'b1);

        // 5: the refused command leaves a beat with nothing to match
        beat({16{8'h14}});
        chk("t5_unexp", unexp_rd_o, 1'b1);
        chk("t5_err", error_check_o, 1'b1);
        chk("t5_cnt", err_cnt_o, 16'h0);
        do_clear();
        chk("t5_clr_unexp", unexp_rd_o, 1'b0);
        chk("t5_clr_err", error_check_o, 1'b0);

        // 6: reset mid-burst, then next command starts from beat 0
        push(8'h50, 11'd4, 4'd0, 4'd15, 8'h77);
        beat({16{8'h77}});
        beat({16{8'h00}});
        chk("t6_pre_err", error_check_o, 1'b1);
        rst_i = 1'b1;
        tick();
        chk("t6_rst_err", error_check_o, 1'b0);
        chk("t6_rst_cnt", err_cnt_o, 16'h0);
        chk("t6_rst_busy", busy_o, 1'b0);
        chk("t6_rst_addr", err_addr_o, 8'h00);
        rst_i = 1'b0;
        tick();
        push(8'h60, 11'd2, 4'd0, 4'd15, 8'h66);
        d = {16{8'h66}};
        d[7:0] = 8'h00;
        beat(d);
        beat({16{8'h66}});
        chk("t6_addr", err_addr_o, 8'h60);
        chk("t6_cnt", err_cnt_o, 16'h1);
        chk("t6_busy", busy_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
